sc_serial_shifter: RTL

- Slow-control serial shifter for the front-end ASIC configuration chain.
- Consumes the one-cycle tick produced by the clock divider stage and bit-bangs a parallel configuration word out MSB-first on sr_clk/sr_din. It then issues a load strobe.
- Captures the word shifted back out of the daisy chain on sr_dout, so firmware can verify the previous configuration.
- All logic runs on the system clock; the tick only gates state advances.

---
 rtl/sc_serial_shifter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sc_serial_shifter.sv
// Slow-control serial shifter. Bit-bangs a configuration word MSB-first to the
// front-end ASIC chain, pulses the load strobe and captures the returned word.
module sc_serial_shifter #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  tick_in,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sr_clk,
  output logic                  sr_din,
  output logic                  sr_load,
  input  logic                  sr_dout,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  rb_match
);

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    LOAD_END
  } state_t;

  state_t state;
  state_t next_state;

  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] cur_cfg;
  logic [DATA_WIDTH-1:0] rb_shift;
  logic [DATA_WIDTH-1:0] last_cfg;
  logic                  last_valid;
  logic [CNT_WIDTH-1:0]  cnt;

  logic accept;
  logic drive_bit;
  logic clock_bit;
  logic start_load;
  logic finish;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The tick only gates advances; a tick coincident with acceptance is not consumed.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    drive_bit  = 1'b0;
    clock_bit  = 1'b0;
    start_load = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (tick_in) begin
          drive_bit  = 1'b1;
          next_state = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (tick_in) begin
          clock_bit  = 1'b1;
          next_state = (cnt == LAST_BIT) ? LOAD : SHIFT_LO;
        end
      end
      LOAD: begin
        if (tick_in) begin
          start_load = 1'b1;
          next_state = LOAD_END;
        end
      end
      LOAD_END: begin
        if (tick_in) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      sr_clk     <= 1'b0;
      sr_din     <= 1'b0;
      sr_load    <= 1'b0;
      rb_data    <= '0;
      rb_match   <= 1'b0;
      shreg      <= '0;
      cur_cfg    <= '0;
      rb_shift   <= '0;
      last_cfg   <= '0;
      last_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        shreg   <= cfg_data;
        cur_cfg <= cfg_data;
        cnt     <= '0;
        busy    <= 1'b1;
      end
      if (drive_bit) begin
        sr_clk <= 1'b0;
        sr_din <= shreg[DATA_WIDTH-1];
      end
      // sr_dout is sampled here, i.e. before the slave sees this rising edge.
      if (clock_bit) begin
        sr_clk   <= 1'b1;
        rb_shift <= {rb_shift[DATA_WIDTH-2:0], sr_dout};
        shreg    <= shreg << 1;
        if (cnt != LAST_BIT) begin
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end
      if (start_load) begin
        sr_clk  <= 1'b0;
        sr_din  <= 1'b0;
        sr_load <= 1'b1;
      end
      if (finish) begin
        sr_load    <= 1'b0;
        busy       <= 1'b0;
        rb_data    <= rb_shift;
        rb_match   <= last_valid && (rb_shift == last_cfg);
        last_cfg   <= cur_cfg;
        last_valid <= 1'b1;
      end
    end
  end

  a_no_clk_during_load : assert property (@(posedge clk_in) disable iff (rst)
    !(sr_clk && sr_load));

  a_din_stable_on_rise : assert property (@(posedge clk_in) disable iff (rst)
    $rose(sr_clk) |-> $stable(sr_din));

endmodule
